// File: rtl/sumador_arb_pkg.sv
// Shared definitions for the two-channel add/sub arbiter.
// Holds the FSM state encoding, the op encoding, the default datapath width
// and a saturating increment used by the optional statistics counters.
package sumador_arb_pkg;

  localparam int WIDTH_DEF = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant logic.
// Ports:
//   valid_i      request valids, bit n for requester n
//   prio_i       requester that wins when both are valid
//   grant_o      granted requester index
//   any_valid_o  at least one request is present
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  output logic       grant_o,
  output logic       any_valid_o
);

  always_comb begin
    any_valid_o = |valid_i;
    if (&valid_i) grant_o = prio_i;
    else          grant_o = valid_i[1];
  end

endmodule

// File: rtl/sumador_16bits.sv
// Combinational two's-complement adder/subtractor.
// Ports:
//   a_i, b_i    operands
//   control_i   0 = a+b, 1 = a-b (computed as a + ~b + 1)
//   result_o    result truncated to WIDTH bits
//   overflow_o  signed overflow of the effective addition
module sumador_16bits #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic                    control_i,
  output logic signed [WIDTH-1:0] result_o,
  output logic                    overflow_o
);

  logic signed [WIDTH-1:0] b_eff;

  always_comb begin
    b_eff      = control_i ? ~b_i : b_i;
    result_o   = a_i + b_eff + {{(WIDTH-1){1'b0}}, control_i};
    // Overflow only when both addends share a sign the result does not.
    overflow_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                 (result_o[WIDTH-1] != a_i[WIDTH-1]);
  end

endmodule

// File: rtl/sumador_arbiter.sv
// Shares one add/sub datapath between two valid/ready requester channels
// with round-robin arbitration. Flow: IDLE (accept) -> EXEC (compute) ->
// RESP (hold result until owner consumes it) -> IDLE.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid_n/req_ready_n        request handshake for channel n
//   req_a_n, req_b_n, req_op_n     operands and op (0 add, 1 sub)
//   rsp_valid_n/rsp_ready_n        response handshake for channel n
//   rsp_result_n, rsp_overflow_n   result and signed overflow
// Optional: define SUMADOR_ARB_STATS_EN to add ops_cnt_0, ops_cnt_1 and
// ovf_cnt saturating statistics counters.
module sumador_arbiter
  import sumador_arb_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic             req_op_0,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [WIDTH-1:0] rsp_result_0,
  output logic             rsp_overflow_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic             req_op_1,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_result_1,
  output logic             rsp_overflow_1
`ifdef SUMADOR_ARB_STATS_EN
  ,
  output logic [15:0]      ops_cnt_0,
  output logic [15:0]      ops_cnt_1,
  output logic [15:0]      ovf_cnt
`endif
);

  state_t                  state_q, state_d;
  logic                    prio_q, owner_q;
  logic signed [WIDTH-1:0] a_q, b_q;
  logic                    op_q;
  logic [1:0]              rsp_valid_q;
  logic [WIDTH-1:0]        res0_q, res1_q;
  logic                    ovf0_q, ovf1_q;

  logic                    grant, any_valid;
  logic                    accept, rsp_hs, rsp_ready_own;
  logic signed [WIDTH-1:0] sum_res;
  logic                    sum_ovf;

  rr_arb2 u_arb (
    .valid_i     ({req_valid_1, req_valid_0}),
    .prio_i      (prio_q),
    .grant_o     (grant),
    .any_valid_o (any_valid)
  );

  sumador_16bits #(.WIDTH(WIDTH)) u_sum (
    .a_i        (a_q),
    .b_i        (b_q),
    .control_i  (op_q),
    .result_o   (sum_res),
    .overflow_o (sum_ovf)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / handshake logic; ready depends on valid so a withdrawn
  // request is never accepted.
  always_comb begin
    req_ready_0   = (state_q == ST_IDLE) && any_valid && !grant && req_valid_0;
    req_ready_1   = (state_q == ST_IDLE) && any_valid &&  grant && req_valid_1;
    accept        = req_ready_0 || req_ready_1;
    rsp_ready_own = owner_q ? rsp_ready_1 : rsp_ready_0;
    rsp_hs        = (state_q == ST_RESP) && rsp_ready_own;
  end

  // Operand latch, response registers and round-robin priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q      <= RR_INIT;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      rsp_valid_q <= 2'b00;
      res0_q      <= '0;
      res1_q      <= '0;
      ovf0_q      <= 1'b0;
      ovf1_q      <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= grant;
        a_q     <= grant ? req_a_1  : req_a_0;
        b_q     <= grant ? req_b_1  : req_b_0;
        op_q    <= grant ? req_op_1 : req_op_0;
      end
      if (state_q == ST_EXEC) begin
        if (owner_q) begin
          res1_q <= sum_res;
          ovf1_q <= sum_ovf;
        end else begin
          res0_q <= sum_res;
          ovf0_q <= sum_ovf;
        end
        rsp_valid_q[owner_q] <= 1'b1;
      end
      if (rsp_hs) begin
        rsp_valid_q[owner_q] <= 1'b0;
        prio_q               <= ~owner_q;
      end
    end
  end

  assign rsp_valid_0    = rsp_valid_q[0];
  assign rsp_valid_1    = rsp_valid_q[1];
  assign rsp_result_0   = res0_q;
  assign rsp_result_1   = res1_q;
  assign rsp_overflow_0 = ovf0_q;
  assign rsp_overflow_1 = ovf1_q;

`ifdef SUMADOR_ARB_STATS_EN
  logic own_ovf;
  assign own_ovf = owner_q ? ovf1_q : ovf0_q;

  // Counters advance when the owner consumes its response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_cnt_0 <= 16'h0000;
      ops_cnt_1 <= 16'h0000;
      ovf_cnt   <= 16'h0000;
    end else if (rsp_hs) begin
      if (owner_q) ops_cnt_1 <= sat_inc16(ops_cnt_1);
      else         ops_cnt_0 <= sat_inc16(ops_cnt_0);
      if (own_ovf) ovf_cnt   <= sat_inc16(ovf_cnt);
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_sumador_arbiter.sv
module tb_sumador_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_0, req_ready_0, req_op_0, rsp_valid_0, rsp_ready_0, rsp_overflow_0;
  logic        req_valid_1, req_ready_1, req_op_1, rsp_valid_1, rsp_ready_1, rsp_overflow_1;
  logic [15:0] req_a_0, req_b_0, rsp_result_0;
  logic [15:0] req_a_1, req_b_1, rsp_result_1;
`ifdef SUMADOR_ARB_STATS_EN
  logic [15:0] ops_cnt_0, ops_cnt_1, ovf_cnt;
`endif

  always #5 clk = ~clk;

  sumador_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_a_0(req_a_0),
    .req_b_0(req_b_0), .req_op_0(req_op_0), .rsp_valid_0(rsp_valid_0),
    .rsp_ready_0(rsp_ready_0), .rsp_result_0(rsp_result_0), .rsp_overflow_0(rsp_overflow_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_a_1(req_a_1),
    .req_b_1(req_b_1), .req_op_1(req_op_1), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_1(rsp_ready_1), .rsp_result_1(rsp_result_1), .rsp_overflow_1(rsp_overflow_1)
`ifdef SUMADOR_ARB_STATS_EN
    , .ops_cnt_0(ops_cnt_0), .ops_cnt_1(ops_cnt_1), .ovf_cnt(ovf_cnt)
`endif
  );

  typedef struct {
    int          ch;
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Monitor: pops the scoreboard on every response handshake and checks the
  // accept-to-valid latency of each channel.
  initial begin : monitor
    int          acc_cyc[2];
    logic        pv[2];
    logic        v[2], r[2], o[2];
    logic [15:0] res[2];
    exp_t        e;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    pv[0] = 1'b0;   pv[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv[0] = 1'b0; pv[1] = 1'b0;
        continue;
      end
      if (req_valid_0 && req_ready_0) acc_cyc[0] = cyc;
      if (req_valid_1 && req_ready_1) acc_cyc[1] = cyc;
      v[0] = rsp_valid_0;  r[0] = rsp_ready_0;  o[0] = rsp_overflow_0;  res[0] = rsp_result_0;
      v[1] = rsp_valid_1;  r[1] = rsp_ready_1;  o[1] = rsp_overflow_1;  res[1] = rsp_result_1;
      for (int c = 0; c < 2; c++) begin
        if (v[c] && !pv[c]) chk($sformatf("latency_ch%0d", c), cyc - acc_cyc[c], 2);
        pv[c] = v[c];
        if (v[c] && r[c]) begin
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_rsp_ch%0d: got result %0h with nothing expected", c, res[c]);
          end else begin
            e = sb.pop_front();
            chk("rsp_channel", c, e.ch);
            chk($sformatf("rsp_result_ch%0d", c), {16'h0, res[c]}, {16'h0, e.res});
            chk($sformatf("rsp_ovf_ch%0d", c), {31'h0, o[c]}, {31'h0, e.ovf});
          end
        end
      end
    end
  end

  task automatic drive(input int ch, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic op);
    if (ch == 0) begin
      req_valid_0 = v; req_a_0 = a; req_b_0 = b; req_op_0 = op;
    end else begin
      req_valid_1 = v; req_a_1 = a; req_b_1 = b; req_op_1 = op;
    end
  endtask

  // Issue one request; returns just after the accepting edge.
  task automatic issue(input int ch, input logic [15:0] a, input logic [15:0] b,
                       input logic op, input logic [15:0] er, input logic eo,
                       input bit push);
    exp_t e;
    int   k;
    if (push) begin
      e.ch = ch; e.res = er; e.ovf = eo;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    drive(ch, 1'b1, a, b, op);
    k = 0;
    forever begin
      #1;
      if ((ch == 0 && req_ready_0) || (ch == 1 && req_ready_1)) break;
      k++;
      if (k > 60) begin
        n_total++;
        $display("FAIL accept_timeout_ch%0d: got no req_ready expected acceptance", ch);
        drive(ch, 1'b0, a, b, op);
        return;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    drive(ch, 1'b0, a, b, op);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e;
    int   k;
    rst_n = 1'b0;
    req_valid_0 = 1'b0; req_a_0 = '0; req_b_0 = '0; req_op_0 = 1'b0; rsp_ready_0 = 1'b1;
    req_valid_1 = 1'b0; req_a_1 = '0; req_b_1 = '0; req_op_1 = 1'b0; rsp_ready_1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_rsp_valid_0", {31'h0, rsp_valid_0}, 0);
    chk("rst_rsp_valid_1", {31'h0, rsp_valid_1}, 0);
    chk("rst_result_0", {16'h0, rsp_result_0}, 0);
    chk("rst_result_1", {16'h0, rsp_result_1}, 0);
    chk("rst_ovf_0", {31'h0, rsp_overflow_0}, 0);
    chk("rst_req_ready_0", {31'h0, req_ready_0}, 0);

    // Both channels contending from reset: grants must alternate 0,1,0,1
    e.ch = 0; e.res = 16'hFFFE; e.ovf = 1'b0; sb.push_back(e);
    e.ch = 1; e.res = 16'h7FFF; e.ovf = 1'b1; sb.push_back(e);
    e.ch = 0; e.res = 16'hFFFE; e.ovf = 1'b0; sb.push_back(e);
    e.ch = 1; e.res = 16'h7FFF; e.ovf = 1'b1; sb.push_back(e);
    fork
      begin
        issue(0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0, 1'b0, 1'b0);
        issue(0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0, 1'b0, 1'b0);
      end
      begin
        issue(1, 16'h8000, 16'h0001, 1'b1, 16'h0, 1'b0, 1'b0);
        issue(1, 16'h8000, 16'h0001, 1'b1, 16'h0, 1'b0, 1'b0);
      end
    join
    wait_drain();

    // Single-channel traffic
    issue(0, 16'h2222, 16'h4444, 1'b0, 16'h6666, 1'b0, 1'b1);
    wait_drain();
    issue(1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b1);
    wait_drain();
    issue(1, 16'h4444, 16'h2222, 1'b1, 16'h2222, 1'b0, 1'b1);
    wait_drain();

    // Owner stalls its response for 5 cycles while channel 1 waits
    rsp_ready_0 = 1'b0;
    issue(0, 16'h1234, 16'h0101, 1'b0, 16'h1335, 1'b0, 1'b1);
    e.ch = 1; e.res = 16'hFFFE; e.ovf = 1'b0; sb.push_back(e);
    drive(1, 1'b1, 16'h0005, 16'h0007, 1'b1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid_0 && k < 20);
    chk("stall_rsp_valid_seen", {31'h0, rsp_valid_0}, 1);
    repeat (5) begin
      chk("stall_rsp_valid_0", {31'h0, rsp_valid_0}, 1);
      chk("stall_result_0", {16'h0, rsp_result_0}, 32'h1335);
      chk("stall_req_ready_0", {31'h0, req_ready_0}, 0);
      chk("stall_req_ready_1", {31'h0, req_ready_1}, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready_0 = 1'b1;
    chk("stall_hs_req_ready_1", {31'h0, req_ready_1}, 0);
    @(posedge clk); #2;
    chk("post_hs_req_ready_1", {31'h0, req_ready_1}, 1);
    @(posedge clk); #1;
    drive(1, 1'b0, 16'h0005, 16'h0007, 1'b1);
    wait_drain();

    // Overflow on add of two negatives, leaves priority with channel 1
    issue(0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    wait_drain();
    @(posedge clk); #1;
`ifdef SUMADOR_ARB_STATS_EN
    chk("ops_cnt_0", {16'h0, ops_cnt_0}, 5);
    chk("ops_cnt_1", {16'h0, ops_cnt_1}, 5);
    chk("ovf_cnt", {16'h0, ovf_cnt}, 4);
`endif

    // Reset while an op is in EXEC: no response, priority back to channel 0
    issue(1, 16'h0100, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("exec_rst_rsp_valid_1", {31'h0, rsp_valid_1}, 0);
    chk("exec_rst_result_1", {16'h0, rsp_result_1}, 0);
    chk("exec_rst_ovf_0", {31'h0, rsp_overflow_0}, 0);
`ifdef SUMADOR_ARB_STATS_EN
    chk("exec_rst_ops_cnt_0", {16'h0, ops_cnt_0}, 0);
`endif
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_rsp_valid_0", {31'h0, rsp_valid_0}, 0);
      chk("post_rst_rsp_valid_1", {31'h0, rsp_valid_1}, 0);
    end
    @(posedge clk); #1;
    drive(0, 1'b1, 16'h0001, 16'h0001, 1'b0);
    drive(1, 1'b1, 16'h0001, 16'h0001, 1'b0);
    #1;
    chk("rr_init_ready_0", {31'h0, req_ready_0}, 1);
    chk("rr_init_ready_1", {31'h0, req_ready_1}, 0);
    #1;
    drive(0, 1'b0, 16'h0001, 16'h0001, 1'b0);
    drive(1, 1'b0, 16'h0001, 16'h0001, 1'b0);
    repeat (4) @(negedge clk);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
